// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register index type, default sizing and the
// operation classes that select a freshly issued destination's forwarding delay.
package hazard_scoreboard_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int NREG_DEF     = 32;
  localparam int CNT_W_DEF    = 2;
  localparam int LONG_LAT_DEF = 4;
  localparam int TMR_W_DEF    = 3;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_LONG
  } op_class_e;

  // A long op that is also flagged as a load is treated as long.
  function automatic op_class_e classify(input logic is_load, input logic is_long);
    if (is_long) return OP_LONG;
    if (is_load) return OP_LOAD;
    return OP_ALU;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX/WB-side bus between the pipeline (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  reg_idx_t rs1_id;
  reg_idx_t rs2_id;
  logic     rs1_used;
  logic     rs2_used;
  logic     issue_valid;
  reg_idx_t issue_rd;
  logic     issue_rf_en;
  logic     issue_load;
  logic     issue_long;
  logic     flush_ex;
  logic     wb_rf_en;
  reg_idx_t wb_rd;
  logic     stall_o;
  logic     issue_fire_o;
  logic     long_busy_o;
  logic     err_o;

  modport master (
    output rs1_id, rs2_id, rs1_used, rs2_used,
    output issue_valid, issue_rd, issue_rf_en, issue_load, issue_long,
    output flush_ex, wb_rf_en, wb_rd,
    input  stall_o, issue_fire_o, long_busy_o, err_o
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used, rs2_used,
    input  issue_valid, issue_rd, issue_rf_en, issue_load, issue_long,
    input  flush_ex, wb_rf_en, wb_rd,
    output stall_o, issue_fire_o, long_busy_o, err_o
  );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// Tracking state for one architectural register: in-flight write count,
// cycles until its value is forwardable, and whether the pending write is a long op.
module sb_entry #(
  parameter int CNT_W = 2,
  parameter int TMR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             wb_dec_i,
  input  logic             fl_dec_i,
  input  logic             fl_long_i,
  input  logic [TMR_W-1:0] load_tmr_i,
  input  logic             load_lng_i,
  output logic             cnt_nz_o,
  output logic             tmr_nz_o,
  output logic             lng_o,
  output logic             err_o
);

  localparam int CW = CNT_W + 2;
  localparam logic signed [CW-1:0] CNT_MAX = CW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 lng_q, lng_d;
  logic signed [CW-1:0] sum;

  always_comb begin
    // Net change of all events this cycle; clamping at either end is an error.
    sum   = $signed({2'b00, cnt_q}) + $signed(CW'(inc_i))
          - $signed(CW'(wb_dec_i)) - $signed(CW'(fl_dec_i));
    err_o = 1'b0;
    cnt_d = sum[CNT_W-1:0];
    if (sum[CW-1]) begin
      cnt_d = '0;
      err_o = 1'b1;
    end else if (sum > CNT_MAX) begin
      cnt_d = '1;
      err_o = 1'b1;
    end

    tmr_d = tmr_q;
    if (inc_i)              tmr_d = load_tmr_i;
    else if (fl_dec_i)      tmr_d = '0;
    else if (tmr_q != '0)   tmr_d = tmr_q - TMR_W'(1);

    lng_d = lng_q;
    if (inc_i)                           lng_d = load_lng_i;
    else if ((cnt_d == '0) || fl_long_i) lng_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmr_q <= '0;
      lng_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      lng_q <= lng_d;
    end
  end

  assign cnt_nz_o = (cnt_q != '0);
  assign tmr_nz_o = (tmr_q != '0);
  assign lng_o    = lng_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side register dependency tracker: stalls ID while a source is not yet
// forwardable, while the long unit is busy, or on a WAW behind a long op.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LONG_LAT = LONG_LAT_DEF,
  parameter int TMR_W    = TMR_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave hs
);

  logic [NREG-1:0]  tmr_nz, cnt_nz, lng, err_vec;
  logic [TMR_W-1:0] long_cnt_q, long_cnt_d;
  logic [TMR_W-1:0] load_tmr;
  logic             ex_valid_q, ex_rf_q, ex_long_q, err_q;
  reg_idx_t         ex_rd_q;
  op_class_e        op;
  logic             src_stall, long_stall, waw_stall, stall, fire, flush_hit;

  always_comb begin
    op = classify(hs.issue_load, hs.issue_long);
    case (op)
      OP_LOAD: load_tmr = TMR_W'(1);
      OP_LONG: load_tmr = TMR_W'(LONG_LAT - 1);
      default: load_tmr = '0;
    endcase
  end

  assign src_stall  = (hs.rs1_used && (hs.rs1_id != '0) && tmr_nz[hs.rs1_id])
                   || (hs.rs2_used && (hs.rs2_id != '0) && tmr_nz[hs.rs2_id]);
  assign long_stall = hs.issue_valid && hs.issue_long && (long_cnt_q != '0);
  assign waw_stall  = hs.issue_valid && hs.issue_rf_en && (hs.issue_rd != '0)
                   && lng[hs.issue_rd] && cnt_nz[hs.issue_rd];
  assign stall      = rst_n && (src_stall || long_stall || waw_stall);
  assign fire       = rst_n && hs.issue_valid && !stall && !hs.flush_ex;
  assign flush_hit  = hs.flush_ex && ex_valid_q && ex_rf_q;

  // x0 has no entry; its status bits read as idle.
  assign tmr_nz[0]  = 1'b0;
  assign cnt_nz[0]  = 1'b0;
  assign lng[0]     = 1'b0;
  assign err_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
      logic hit_issue, hit_wb, hit_fl;
      assign hit_issue = fire && hs.issue_rf_en && (hs.issue_rd == reg_idx_t'(gi));
      assign hit_wb    = hs.wb_rf_en && (hs.wb_rd == reg_idx_t'(gi));
      assign hit_fl    = flush_hit && (ex_rd_q == reg_idx_t'(gi));

      sb_entry #(.CNT_W(CNT_W), .TMR_W(TMR_W)) u_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (hit_issue),
        .wb_dec_i   (hit_wb),
        .fl_dec_i   (hit_fl),
        .fl_long_i  (hit_fl && ex_long_q),
        .load_tmr_i (load_tmr),
        .load_lng_i (hs.issue_long),
        .cnt_nz_o   (cnt_nz[gi]),
        .tmr_nz_o   (tmr_nz[gi]),
        .lng_o      (lng[gi]),
        .err_o      (err_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    long_cnt_d = long_cnt_q;
    if (fire && hs.issue_long)          long_cnt_d = TMR_W'(LONG_LAT);
    else if (flush_hit && ex_long_q)    long_cnt_d = '0;
    else if (long_cnt_q != '0)          long_cnt_d = long_cnt_q - TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_cnt_q <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      ex_rf_q    <= 1'b0;
      ex_long_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      ex_valid_q <= fire;
      ex_rd_q    <= hs.issue_rd;
      ex_rf_q    <= hs.issue_rf_en;
      ex_long_q  <= hs.issue_long;
      if (|err_vec) err_q <= 1'b1;
    end
  end

  assign hs.stall_o      = stall;
  assign hs.issue_fire_o = fire;
  assign hs.long_busy_o  = (long_cnt_q != '0);
  assign hs.err_o        = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written corner
// sequences, and randomized traffic against a per-register reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int LL   = 4;
  localparam int CMAX = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if hs_if ();

  hazard_scoreboard #(.NREG(32), .CNT_W(2), .LONG_LAT(LL), .TMR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (hs_if.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, in plain integers.
  int m_cnt[32];
  int m_tmr[32];
  bit m_lng[32];
  int m_lc;
  bit m_exv, m_exrf, m_exlg;
  int m_exrd;
  bit m_err;

  typedef struct {
    bit v; int rd; bit rf; bit ld; bit lg;
    int r1; bit u1; int r2; bit u2;
    bit fl; bit wbe; int wbr;
    bit es; bit ef; bit eb; bit ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t iss(int rd, bit ld, bit lg, int r1, bit u1, int r2, bit u2,
                               bit es, bit ef, bit eb);
    vec_t t;
    t = '{v:1, rd:rd, rf:1, ld:ld, lg:lg, r1:r1, u1:u1, r2:r2, u2:u2,
          fl:0, wbe:0, wbr:0, es:es, ef:ef, eb:eb, ee:0};
    return t;
  endfunction

  function automatic vec_t ret(int wbr, bit eb, bit ee);
    vec_t t;
    t = '{v:0, rd:0, rf:0, ld:0, lg:0, r1:0, u1:0, r2:0, u2:0,
          fl:0, wbe:1, wbr:wbr, es:0, ef:0, eb:eb, ee:ee};
    return t;
  endfunction

  function automatic vec_t idl(bit eb, bit ee);
    vec_t t;
    t = ret(0, eb, ee);
    t.wbe = 0;
    return t;
  endfunction

  task automatic set_in(bit v, int rd, bit rf, bit ld, bit lg, int r1, bit u1,
                        int r2, bit u2, bit fl, bit wbe, int wbr);
    hs_if.issue_valid = v;
    hs_if.issue_rd    = reg_idx_t'(rd);
    hs_if.issue_rf_en = rf;
    hs_if.issue_load  = ld;
    hs_if.issue_long  = lg;
    hs_if.rs1_id      = reg_idx_t'(r1);
    hs_if.rs1_used    = u1;
    hs_if.rs2_id      = reg_idx_t'(r2);
    hs_if.rs2_used    = u2;
    hs_if.flush_ex    = fl;
    hs_if.wb_rf_en    = wbe;
    hs_if.wb_rd       = reg_idx_t'(wbr);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit m_stall();
    bit s;
    s = 0;
    if (hs_if.rs1_used && hs_if.rs1_id != 0 && m_tmr[hs_if.rs1_id] > 0) s = 1;
    if (hs_if.rs2_used && hs_if.rs2_id != 0 && m_tmr[hs_if.rs2_id] > 0) s = 1;
    if (hs_if.issue_valid && hs_if.issue_long && m_lc > 0) s = 1;
    if (hs_if.issue_valid && hs_if.issue_rf_en && hs_if.issue_rd != 0
        && m_lng[hs_if.issue_rd] && m_cnt[hs_if.issue_rd] > 0) s = 1;
    return s;
  endfunction

  function automatic bit m_fire();
    return hs_if.issue_valid && !m_stall() && !hs_if.flush_ex;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0; m_tmr[r] = 0; m_lng[r] = 0;
    end
    m_lc = 0; m_exv = 0; m_exrf = 0; m_exlg = 0; m_exrd = 0; m_err = 0;
  endtask

  task automatic model_update();
    bit f, fh, ins, wbh, flh;
    int n, rd;
    f  = m_fire();
    fh = hs_if.flush_ex && m_exv && m_exrf;
    rd = int'(hs_if.issue_rd);
    for (int r = 1; r < 32; r++) begin
      ins = f && hs_if.issue_rf_en && rd == r;
      wbh = hs_if.wb_rf_en && int'(hs_if.wb_rd) == r;
      flh = fh && m_exrd == r;
      n = m_cnt[r] + (ins ? 1 : 0) - (wbh ? 1 : 0) - (flh ? 1 : 0);
      if (n < 0) begin n = 0; m_err = 1; end
      else if (n > CMAX) begin n = CMAX; m_err = 1; end
      if (ins) begin
        m_tmr[r] = hs_if.issue_long ? LL - 1 : (hs_if.issue_load ? 1 : 0);
        m_lng[r] = hs_if.issue_long;
      end else begin
        if (flh) m_tmr[r] = 0;
        else if (m_tmr[r] > 0) m_tmr[r] = m_tmr[r] - 1;
        if (n == 0 || (flh && m_exlg)) m_lng[r] = 0;
      end
      m_cnt[r] = n;
    end
    if (f && hs_if.issue_long) m_lc = LL;
    else if (fh && m_exlg)     m_lc = 0;
    else if (m_lc > 0)         m_lc = m_lc - 1;
    m_exv  = f;
    m_exrd = rd;
    m_exrf = hs_if.issue_rf_en;
    m_exlg = hs_if.issue_long;
  endtask

  task automatic check(string name, logic got, logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic step(string tag, bit es, bit ef, bit eb, bit ee);
    @(negedge clk);
    check({tag, " stall"}, hs_if.stall_o, es);
    check({tag, " fire"},  hs_if.issue_fire_o, ef);
    check({tag, " busy"},  hs_if.long_busy_o, eb);
    check({tag, " err"},   hs_if.err_o, ee);
    $display("[TB] %s v=%0b rd=%0d rs1=%0d rs2=%0d fl=%0b wb=%0b/%0d -> stall=%0b fire=%0b busy=%0b err=%0b",
             tag, hs_if.issue_valid, hs_if.issue_rd, hs_if.rs1_id, hs_if.rs2_id,
             hs_if.flush_ex, hs_if.wb_rf_en, hs_if.wb_rd,
             hs_if.stall_o, hs_if.issue_fire_o, hs_if.long_busy_o, hs_if.err_o);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t t;
    int   wq[$];
    idle();
    do_reset();

    // lw x5 ; add x6,x5,x1 -> one bubble
    tbl.push_back(iss(5, 1, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(iss(6, 0, 0, 5, 1, 1, 1, 1, 0, 0));
    tbl.push_back(iss(6, 0, 0, 5, 1, 1, 1, 0, 1, 0));
    tbl.push_back(ret(5, 0, 0));
    tbl.push_back(ret(6, 0, 0));
    // add x5 ; sub x7,x5,x2 -> no stall
    tbl.push_back(iss(5, 0, 0, 1, 1, 2, 1, 0, 1, 0));
    tbl.push_back(iss(7, 0, 0, 5, 1, 2, 1, 0, 1, 0));
    tbl.push_back(ret(5, 0, 0));
    tbl.push_back(ret(7, 0, 0));
    // mul x8 ; add x9,x8,x0 -> three stalls
    tbl.push_back(iss(8, 0, 1, 1, 1, 2, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(iss(9, 0, 0, 8, 1, 0, 1, 1, 0, 1));
    tbl.push_back(iss(9, 0, 0, 8, 1, 0, 1, 0, 1, 1));
    // mul x10 ; mul x11 waits for the long unit
    tbl.push_back(iss(10, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(iss(11, 0, 1, 2, 1, 0, 0, 1, 0, 1));
    tbl.push_back(iss(11, 0, 1, 2, 1, 0, 0, 0, 1, 0));
    // addi x8 behind pending mul x8 (WAW) until x8 retires
    tbl.push_back(iss(8, 0, 0, 1, 1, 0, 0, 1, 0, 1));
    t = iss(8, 0, 0, 1, 1, 0, 0, 1, 0, 1); t.wbe = 1; t.wbr = 8; tbl.push_back(t);
    tbl.push_back(iss(8, 0, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(ret(9, 1, 0));
    tbl.push_back(ret(10, 0, 0));
    tbl.push_back(ret(11, 0, 0));
    tbl.push_back(ret(8, 0, 0));
    // lw x5 flushed in EX; later use of x5 is free
    tbl.push_back(iss(5, 1, 0, 1, 1, 0, 0, 0, 1, 0));
    t = iss(12, 0, 0, 3, 1, 0, 0, 0, 0, 0); t.fl = 1; tbl.push_back(t);
    tbl.push_back(iss(6, 0, 0, 5, 1, 0, 0, 0, 1, 0));
    // mul x13 flushed: timer, long unit and WAW state all released
    tbl.push_back(iss(13, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    t = idl(1, 0); t.fl = 1; tbl.push_back(t);
    tbl.push_back(iss(14, 0, 0, 13, 1, 0, 0, 0, 1, 0));
    tbl.push_back(iss(13, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(ret(6, 1, 0));
    tbl.push_back(ret(14, 1, 0));
    tbl.push_back(ret(13, 1, 0));
    // x0 never tracked
    tbl.push_back(iss(0, 1, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(iss(15, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(ret(15, 0, 0));
    tbl.push_back(ret(0, 0, 0));
    // retire of an untracked register -> sticky error
    tbl.push_back(ret(3, 0, 0));
    tbl.push_back(idl(0, 1));
    tbl.push_back(idl(0, 1));

    foreach (tbl[i]) begin
      set_in(tbl[i].v, tbl[i].rd, tbl[i].rf, tbl[i].ld, tbl[i].lg, tbl[i].r1, tbl[i].u1,
             tbl[i].r2, tbl[i].u2, tbl[i].fl, tbl[i].wbe, tbl[i].wbr);
      step($sformatf("row%0d", i), tbl[i].es, tbl[i].ef, tbl[i].eb, tbl[i].ee);
    end

    // Reset clears the sticky error and everything else
    do_reset();
    step("post_rst", 0, 0, 0, 0);

    // Counter overflow on the fourth outstanding write to x20
    for (int i = 0; i < 4; i++) begin
      set_in(1, 20, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      step($sformatf("ovf%0d", i), 0, 1, 0, 0);
    end
    idle();
    step("ovf_err", 0, 0, 0, 1);

    // Reset in the middle of a long op discards its tracking
    do_reset();
    set_in(1, 8, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    step("mid_mul", 0, 1, 0, 0);
    do_reset();
    set_in(1, 9, 1, 0, 0, 8, 1, 0, 1, 0, 0, 0);
    step("mid_use", 0, 1, 0, 0);
    set_in(1, 10, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    step("mid_mul2", 0, 1, 0, 0);
    set_in(1, 8, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("mid_waw", 0, 1, 1, 0);

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        int  op, rd, wbr;
        bit  wbe;
        op  = int'($urandom_range(0, 3));
        rd  = int'($urandom_range(0, 7));
        wbe = 0;
        wbr = 0;
        wq.delete();
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) wq.push_back(r);
        if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
          wbe = 1;
          wbr = wq[$urandom_range(0, wq.size() - 1)];
        end else if ($urandom_range(0, 63) == 0) begin
          wbe = 1;
          wbr = int'($urandom_range(0, 31));
        end
        set_in($urandom_range(0, 3) != 0, rd, $urandom_range(0, 7) != 0,
               op == 1, op == 2,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 11) == 0, wbe, wbr);
        step($sformatf("rnd%0d_%0d", blk, c), m_stall(), m_fire(), m_lc > 0, m_err);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
